pipeline_elastic_registers: RTL and testbench

//  Parametrised elastic pipeline: NUMBER_OF_STAGES register stages carrying a
//  BIT_WIDTH payload under a valid/ready handshake, with backpressure, bubble

---
 rtl/pipeline_elastic_stage.sv | 27 ++
 rtl/pipeline_elastic_registers.sv | 72 +++++++
 tb/tb_pipeline_elastic_registers.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_elastic_stage.sv
// One elastic register slot: holds a valid bit and payload, advancing whenever
// the combinational ready term for this slot is high.
module pipeline_elastic_stage #(
  parameter int BIT_WIDTH  = 10,
  parameter int RESET_DATA = 1
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 ready,
  input  logic                 up_valid,
  input  logic [BIT_WIDTH-1:0] up_data,
  output logic                 valid,
  output logic [BIT_WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (clear) begin
      valid <= 1'b0;
      if (RESET_DATA != 0) data <= '0;
    end else if (ready) begin
      valid <= up_valid;
      // Payload only moves with a real beat, so bubbles never overwrite data.
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/pipeline_elastic_registers.sv
// Elastic valid/ready pipeline of NUMBER_OF_STAGES slots with bubble collapsing,
// backpressure, synchronous flush and an occupancy count.
module pipeline_elastic_registers #(
  parameter  int BIT_WIDTH        = 10,
  parameter  int NUMBER_OF_STAGES = 5,
  parameter  int RESET_DATA       = 1,
  localparam int OCC_W            = (NUMBER_OF_STAGES > 0) ? $clog2(NUMBER_OF_STAGES + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]     occupancy
);

  if (NUMBER_OF_STAGES == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, reset};

    assign out_valid = in_valid & ~flush;
    assign in_ready  = out_ready & ~flush;
    assign out_data  = in_data;
    assign occupancy = '0;
  end else begin : g_pipe
    localparam int unsigned N = NUMBER_OF_STAGES;

    logic                 clear;
    logic [N:0]           vchain;
    logic [BIT_WIDTH-1:0] dchain [N+1];
    logic [N-1:0]         ready;

    assign clear     = reset | flush;
    assign vchain[0] = in_valid;
    assign dchain[0] = in_data;

    for (genvar k = 0; k < N; k++) begin : g_stage
      // Closed form of ready_k = !valid_k | ready_{k+1}: a slot can take a beat
      // unless it and every slot downstream of it are full and the sink stalls.
      assign ready[k] = out_ready | ~(&vchain[N:k+1]);

      pipeline_elastic_stage #(
        .BIT_WIDTH (BIT_WIDTH),
        .RESET_DATA(RESET_DATA)
      ) u_stage (
        .clk     (clk),
        .clear   (clear),
        .ready   (ready[k]),
        .up_valid(vchain[k]),
        .up_data (dchain[k]),
        .valid   (vchain[k+1]),
        .data    (dchain[k+1])
      );
    end

    assign in_ready  = ready[0] & ~clear;
    assign out_valid = vchain[N] & ~clear;
    assign out_data  = dchain[N];

    always_comb begin
      occupancy = '0;
      for (int unsigned i = 1; i <= N; i++) begin
        occupancy = occupancy + OCC_W'(vchain[i]);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_elastic_registers.sv
// Bench for the elastic pipeline: directed cases on N=5 plus random traffic on
// N=5, N=1 and N=0, all compared every cycle against a queue-based model.
module tb_pipeline_elastic_registers;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, flush;
  logic iv5, ir5, ov5, or5;
  logic [W-1:0] id5, od5;
  logic [2:0] occ5;
  logic iv1, ir1, ov1, or1;
  logic [W-1:0] id1, od1;
  logic [0:0] occ1;
  logic iv0, ir0, ov0, or0;
  logic [W-1:0] id0, od0;
  logic [0:0] occ0;

  pipeline_elastic_registers #(.BIT_WIDTH(W), .NUMBER_OF_STAGES(5), .RESET_DATA(1)) dut5 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv5), .in_ready(ir5), .in_data(id5),
    .out_valid(ov5), .out_ready(or5), .out_data(od5), .occupancy(occ5));

  pipeline_elastic_registers #(.BIT_WIDTH(W), .NUMBER_OF_STAGES(1), .RESET_DATA(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1));

  pipeline_elastic_registers #(.BIT_WIDTH(W), .NUMBER_OF_STAGES(0), .RESET_DATA(1)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(occ0));

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;
  bit done = 1'b0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic [31:0]  t;
  } beat_t;

  beat_t q5[$];
  beat_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Model: a beat accepted in cycle t may leave from cycle t+N onward once it is
  // the oldest beat; the input stalls only when N beats are held and the sink stalls.
  always @(negedge clk) begin : model
    bit clr, e_ir, e_ov;
    beat_t b;
    if (armed) begin
      clr = reset | flush;

      e_ir = !clr && (q5.size() < 5 || or5);
      e_ov = !clr && q5.size() > 0 && cyc >= q5[0].t + 5;
      chk("n5_in_ready", ir5, e_ir);
      chk("n5_out_valid", ov5, e_ov);
      chk("n5_occupancy", occ5, q5.size());
      if (e_ov) chk("n5_out_data", od5, q5[0].d);
      if (clr) q5.delete();
      else begin
        if (e_ov && or5) void'(q5.pop_front());
        if (iv5 && e_ir) begin b.d = id5; b.t = cyc; q5.push_back(b); end
      end

      e_ir = !clr && (q1.size() < 1 || or1);
      e_ov = !clr && q1.size() > 0 && cyc >= q1[0].t + 1;
      chk("n1_in_ready", ir1, e_ir);
      chk("n1_out_valid", ov1, e_ov);
      chk("n1_occupancy", occ1, q1.size());
      if (e_ov) chk("n1_out_data", od1, q1[0].d);
      if (clr) q1.delete();
      else begin
        if (e_ov && or1) void'(q1.pop_front());
        if (iv1 && e_ir) begin b.d = id1; b.t = cyc; q1.push_back(b); end
      end

      chk("n0_in_ready", ir0, or0 && !flush);
      chk("n0_out_valid", ov0, iv0 && !flush);
      chk("n0_out_data", od0, id0);
      chk("n0_occupancy", occ0, 0);
    end
    cyc++;
  end

  initial begin : side_driver
    iv1 = 1'b0; id1 = '0; or1 = 1'b0;
    iv0 = 1'b0; id0 = '0; or0 = 1'b0;
    while (!done) begin
      nxt();
      iv1 = 1'($urandom_range(1));
      id1 = W'($urandom);
      or1 = 1'($urandom_range(1));
      iv0 = 1'($urandom_range(1));
      id0 = W'($urandom);
      or0 = 1'($urandom_range(1));
    end
  end

  task automatic drain();
    iv5 = 1'b0;
    or5 = 1'b1;
    repeat (8) nxt();
  endtask

  initial begin : main
    reset = 1'b1; flush = 1'b0;
    iv5 = 1'b0; id5 = '0; or5 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b1;
    #2;
    chk("reset_out_valid", ov5, 0);
    chk("reset_in_ready", ir5, 1);
    chk("reset_occupancy", occ5, 0);
    chk("reset_out_data", od5, 0);
    nxt();

    for (int c = 0; c < 30; c++) begin
      iv5 = (c < 20); id5 = W'(c + 1); or5 = 1'b1;
      #2;
      chk("stream_valid", ov5, (c >= 5 && c < 25));
      if (c >= 5 && c < 25) chk("stream_data", od5, c - 4);
      nxt();
    end
    drain();

    for (int c = 0; c < 8; c++) begin
      iv5 = 1'b1; or5 = 1'b0; id5 = W'(((c < 5) ? c : 5) + 1);
      #2;
      chk("bp_in_ready", ir5, c < 5);
      chk("bp_occupancy", occ5, (c < 5) ? c : 5);
      if (c >= 5) begin
        chk("bp_out_valid", ov5, 1);
        chk("bp_out_data_stable", od5, 1);
      end
      nxt();
    end
    for (int r = 0; r < 6; r++) begin
      iv5 = 1'b0; or5 = 1'b1;
      #2;
      chk("bp_release_in_ready", ir5, 1);
      chk("bp_release_valid", ov5, r < 5);
      if (r < 5) chk("bp_release_order", od5, r + 1);
      nxt();
    end
    drain();

    for (int c = 0; c < 11; c++) begin
      or5 = 1'b0;
      iv5 = (c == 0 || c == 2);
      id5 = (c == 0) ? W'('h11) : (c == 2) ? W'('h22) : '0;
      #2;
      chk("bubble_in_ready", ir5, 1);
      if (c == 10) begin
        chk("bubble_occupancy", occ5, 2);
        chk("bubble_out_valid", ov5, 1);
        chk("bubble_out_data", od5, 'h11);
      end
      nxt();
    end
    for (int r = 0; r < 3; r++) begin
      iv5 = 1'b0; or5 = 1'b1;
      #2;
      chk("bubble_drain_valid", ov5, r < 2);
      if (r < 2) chk("bubble_drain_data", od5, (r == 0) ? 'h11 : 'h22);
      nxt();
    end
    drain();

    for (int c = 0; c < 10; c++) begin
      or5 = 1'b1;
      flush = (c == 3);
      iv5 = (c < 3 || c == 4);
      id5 = (c == 4) ? W'('hAA) : W'('h31 + c);
      #2;
      if (c == 3) begin
        chk("flush_occupancy_before", occ5, 3);
        chk("flush_out_valid", ov5, 0);
        chk("flush_in_ready", ir5, 0);
      end
      if (c == 4) begin
        chk("flush_occupancy_after", occ5, 0);
        chk("flush_data_cleared", od5, 0);
        chk("flush_in_ready_after", ir5, 1);
      end
      if (c >= 4 && c < 9) chk("flush_no_early_out", ov5, 0);
      if (c == 9) begin
        chk("flush_next_beat_valid", ov5, 1);
        chk("flush_next_beat_data", od5, 'hAA);
      end
      nxt();
    end
    flush = 1'b0;
    drain();

    for (int c = 0; c < 11; c++) begin
      or5 = 1'b1;
      reset = (c == 3);
      iv5 = (c < 3);
      id5 = W'('h50 + c);
      #2;
      if (c == 3) chk("midreset_in_ready", ir5, 0);
      if (c == 4) chk("midreset_occupancy", occ5, 0);
      if (c >= 3) chk("midreset_discard", ov5, 0);
      nxt();
    end
    reset = 1'b0;

    for (int c = 0; c < 1000; c++) begin
      iv5 = 1'($urandom_range(1));
      id5 = W'($urandom);
      or5 = ($urandom_range(3) != 0);
      flush = ($urandom_range(63) == 0);
      reset = ($urandom_range(199) == 0);
      nxt();
    end
    reset = 1'b0;
    flush = 1'b0;
    drain();
    done = 1'b1;
    nxt();
    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
